// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared opcode/state types and default width for the bit-serial ALU
package serial_alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - one-bit ALU slice: AND, OR, or full add with B inverted for SUB
module serial_alu_bit
    import serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_e  op,
    output logic result,
    output logic cout
);

    logic b_eff;

    always_comb begin
        result = 1'b0;
        cout   = 1'b0;
        b_eff  = b ^ op[0];
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: begin
                result = a ^ b_eff ^ cin;
                cout   = (a & b_eff) | (cin & (a ^ b_eff));
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// rtl/serial_alu_sequencer.sv - bit-serial ALU: accepts an operand bundle, processes one bit
// per cycle LSB first, then holds the result until the consumer takes it.
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    serial_alu_bit u_bit (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry_q),
        .op     (op_q),
        .result (slice_res),
        .cout   (slice_cout)
    );

    assign res_next  = {slice_res, res_sh[WIDTH-1:1]};
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_AND;
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            cnt          <= '0;
            carry_q      <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= in_a;
                        b_sh    <= in_b;
                        op_q    <= op_e'(in_op);
                        carry_q <= in_op[0];
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next;
                    carry_q <= slice_cout;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB; overflow compares it to carry out
                        out_result   <= res_next;
                        out_carry    <= op_q[1] & slice_cout;
                        out_overflow <= op_q[1] & (carry_q ^ slice_cout);
                        out_zero     <= (res_next == '0);
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
